// File: rtl/io_bus_ctrl.sv
// Memory-mapped I/O block behind the cpu bus (mem_a[17:16]==2'b11).
// It buffers UART TX bytes, pops UART RX bytes, serves a coherent cycle counter and runs the stop handshake.
module io_bus_ctrl #(
  parameter int TX_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  io_din,
  output logic        io_sel_q,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        overflow,
  output logic        program_done
);
  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {RUN, STOPPING, HALTED} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   cyc_q, snap_q, snap_d;
  logic [7:0]    io_din_q, io_din_d;
  logic          io_sel_d, overflow_q, overflow_d, pend_q, pend_d;
  logic [7:0]    fifo_mem [TX_DEPTH];

  logic       io_hit, io, io_rd, full, pop, push, drop;
  logic       wr_byte, wr_stop;
  logic [2:0] off;
  logic [7:0] push_byte;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^{mem_a[31:18], mem_a[15:3]};

  assign io_hit  = (mem_a[17:16] == 2'b11);
  assign io      = rdy_in & io_hit;
  assign io_rd   = io & ~mem_wr;
  assign off     = mem_a[2:0];
  assign full    = (count_q == CW'(TX_DEPTH));
  assign wr_byte = io & mem_wr & (off == 3'd0) & (mem_dout != 8'h00) & (state_q == RUN);
  assign wr_stop = io & mem_wr & (off == 3'd4) & (state_q == RUN);

  assign tx_valid       = (count_q != '0);
  assign tx_data        = tx_valid ? fifo_mem[rd_ptr_q] : 8'h00;
  assign pop            = tx_valid & tx_ready;
  assign io_buffer_full = full;
  assign rx_pop         = io_rd & (off == 3'd0) & rx_valid;
  assign io_din         = io_din_q;
  assign overflow       = overflow_q;
  assign program_done   = (state_q == HALTED);

  // A deferred stop marker only ever exists in STOPPING, where cpu writes are blocked, so it never collides with one.
  always_comb begin
    push      = 1'b0;
    drop      = 1'b0;
    push_byte = wr_byte ? mem_dout : 8'h00;
    pend_d    = pend_q;
    if (wr_byte || wr_stop) begin
      if (!full || pop) push = 1'b1;
      else              drop = 1'b1;
      if (wr_stop && full && !pop) pend_d = 1'b1;
    end else if (pend_q && !full) begin
      push   = 1'b1;
      pend_d = 1'b0;
    end
    overflow_d = overflow_q | drop;
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
  end

  // Offsets 5..7 come from the snapshot taken at offset 4, so a byte-serial word read never tears across a carry.
  always_comb begin
    io_din_d = io_din_q;
    snap_d   = snap_q;
    io_sel_d = rdy_in ? io_hit : io_sel_q;
    if (io_rd) begin
      unique case (off)
        3'd0:    io_din_d = rx_valid ? rx_data : 8'h00;
        3'd4: begin
          io_din_d = cyc_q[7:0];
          snap_d   = cyc_q;
        end
        3'd5:    io_din_d = snap_q[15:8];
        3'd6:    io_din_d = snap_q[23:16];
        3'd7:    io_din_d = snap_q[31:24];
        default: io_din_d = 8'h00;
      endcase
    end
  end

  // The marker is the last byte in the FIFO, so an empty FIFO with nothing pending means it has gone out.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (wr_stop) state_d = STOPPING;
      STOPPING: if (!pend_q && count_d == '0) state_d = HALTED;
      HALTED:   state_d = HALTED;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cyc_q      <= '0;
      snap_q     <= '0;
      io_din_q   <= 8'h00;
      io_sel_q   <= 1'b0;
      overflow_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cyc_q      <= cyc_q + 32'd1;
      snap_q     <= snap_d;
      io_din_q   <= io_din_d;
      io_sel_q   <= io_sel_d;
      overflow_q <= overflow_d;
      pend_q     <= pend_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr_q] <= push_byte;
  end
endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed bench for io_bus_ctrl: a vector table for single-cycle bus behaviour,
// plus hand sequences for FIFO full/drain, counter coherency, async reset and the stop handshake.
module tb_io_bus_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b0;
  logic [31:0] addr = '0;
  logic [7:0]  dout = '0;
  logic        wr = 1'b0;
  logic [7:0]  io_din;
  logic        io_sel_q;
  logic        full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_pop;
  logic        overflow;
  logic        program_done;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_cyc;

  io_bus_ctrl #(.TX_DEPTH(8)) dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .mem_a(addr), .mem_dout(dout), .mem_wr(wr),
    .io_din(io_din), .io_sel_q(io_sel_q), .io_buffer_full(full), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_pop(rx_pop), .overflow(overflow), .program_done(program_done)
  );

  always #5 clk = ~clk;

  // Expected cycle counter: counts every edge while out of reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_cyc <= '0;
    else        m_cyc <= m_cyc + 32'd1;
  end

  typedef struct {
    logic        rdy, wr;
    logic [31:0] addr;
    logic [7:0]  dout;
    logic        txr, rxv;
    logic [7:0]  rxd;
    logic        e_pop;
    logic [7:0]  e_din;
    logic        e_sel, e_tv;
    logic [7:0]  e_td;
    logic        e_full;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus(input logic r, input logic w, input logic [31:0] a, input logic [7:0] d);
    rdy = r; wr = w; addr = a; dout = d;
  endtask

  initial begin
    logic [31:0] exp_word, got_word;
    logic [7:0]  stop_exp [3];
    int guard;

    //          rdy   wr    addr          dout   txr   rxv   rxd    pop   din    sel   tv    td     full
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0003_0001, 8'h00, 1'b0, 1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b0, 1'b1, 8'h33, 1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0010, 8'h00, 1'b0, 1'b1, 8'h44, 1'b0, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0003_0000, 8'h00, 1'b0, 1'b1, 8'h66, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0000_0020, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'h0003_0000, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 32'h0003_0002, 8'h42, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 32'h0003_0000, 8'h43, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0020, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 32'h0003_0000, 8'h44, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h44, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 32'h0003_0000, 8'h45, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_io_din", io_din, 8'h00);
    chk("rst_io_sel", io_sel_q, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_rx_pop", rx_pop, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_done", program_done, 1'b0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) begin
      bus(vecs[i].rdy, vecs[i].wr, vecs[i].addr, vecs[i].dout);
      tx_ready = vecs[i].txr; rx_valid = vecs[i].rxv; rx_data = vecs[i].rxd;
      #1;
      chk($sformatf("v%0d_rx_pop", i), rx_pop, vecs[i].e_pop);
      tick();
      chk($sformatf("v%0d_io_din", i), io_din, vecs[i].e_din);
      chk($sformatf("v%0d_io_sel", i), io_sel_q, vecs[i].e_sel);
      chk($sformatf("v%0d_tx_valid", i), tx_valid, vecs[i].e_tv);
      chk($sformatf("v%0d_tx_data", i), tx_data, vecs[i].e_td);
      chk($sformatf("v%0d_full", i), full, vecs[i].e_full);
      $display("vec %0d: rdy=%0b wr=%0b a=%h d=%h -> din=%h sel=%0b tv=%0b td=%h",
               i, vecs[i].rdy, vecs[i].wr, vecs[i].addr, vecs[i].dout, io_din, io_sel_q, tx_valid, tx_data);
    end
    rx_valid = 1'b0;

    // Fill past capacity with the UART stalled, then drain in order.
    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      bus(1'b1, 1'b1, 32'h0003_0000, 8'(i));
      tick();
      chk($sformatf("fill%0d_full", i), full, (i >= 8));
      chk($sformatf("fill%0d_overflow", i), overflow, (i == 9));
      $display("fill write %h: full=%0b overflow=%0b", 8'(i), full, overflow);
    end
    bus(1'b1, 1'b0, 32'h0000_0000, 8'h00);
    tx_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain%0d_tv", k), tx_valid, 1'b1);
      chk($sformatf("drain%0d_td", k), tx_data, 8'(k));
      $display("drain pop %h", tx_data);
      tick();
      if (k == 1) chk("drain_full_drop", full, 1'b0);
    end
    chk("drain_empty", tx_valid, 1'b0);

    // Byte-serial counter read across a carry out of the low byte.
    bus(1'b1, 1'b0, 32'h0000_0000, 8'h00);
    guard = 0;
    while (!(m_cyc[7:0] == 8'hFF && m_cyc >= 32'h100) && guard < 1000) begin
      tick();
      guard++;
    end
    chk("cyc_wait_in_budget", (guard < 1000), 1'b1);
    exp_word = m_cyc;
    bus(1'b1, 1'b0, 32'h0003_0004, 8'h00); tick(); got_word[7:0]   = io_din;
    bus(1'b1, 1'b0, 32'h0003_0005, 8'h00); tick(); got_word[15:8]  = io_din;
    bus(1'b1, 1'b0, 32'h0003_0006, 8'h00); tick(); got_word[23:16] = io_din;
    bus(1'b1, 1'b0, 32'h0003_0007, 8'h00); tick(); got_word[31:24] = io_din;
    chk("cyc_coherent", got_word, exp_word);
    $display("counter read %h (expected %h)", got_word, exp_word);

    // Asynchronous reset in the middle of a drain.
    tx_ready = 1'b0;
    bus(1'b1, 1'b1, 32'h0003_0000, 8'h11); tick();
    bus(1'b1, 1'b1, 32'h0003_0000, 8'h12); tick();
    bus(1'b1, 1'b1, 32'h0003_0000, 8'h13); tick();
    bus(1'b1, 1'b0, 32'h0003_0000, 8'h00); rx_valid = 1'b1; rx_data = 8'h5A; tick();
    rx_valid = 1'b0;
    bus(1'b1, 1'b0, 32'h0000_0000, 8'h00);
    tx_ready = 1'b1;
    @(posedge clk);
    #2;
    chk("pre_rst_tv", tx_valid, 1'b1);
    chk("pre_rst_td", tx_data, 8'h12);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_valid", tx_valid, 1'b0);
    chk("midrst_tx_data", tx_data, 8'h00);
    chk("midrst_io_din", io_din, 8'h00);
    chk("midrst_io_sel", io_sel_q, 1'b0);
    chk("midrst_overflow", overflow, 1'b0);
    chk("midrst_full", full, 1'b0);
    chk("midrst_rx_pop", rx_pop, 1'b0);
    $display("async reset mid-drain: tv=%0b din=%h sel=%0b ovf=%0b", tx_valid, io_din, io_sel_q, overflow);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("postrst_fifo_empty", tx_valid, 1'b0);
    bus(1'b1, 1'b0, 32'h0003_0005, 8'h00); tick();
    chk("postrst_snap_clear", io_din, 8'h00);

    // Stop handshake: marker follows queued bytes, then everything is ignored.
    tx_ready = 1'b0;
    stop_exp[0] = 8'h48; stop_exp[1] = 8'h49; stop_exp[2] = 8'h00;
    bus(1'b1, 1'b1, 32'h0003_0000, 8'h48); tick();
    bus(1'b1, 1'b1, 32'h0003_0000, 8'h49); tick();
    bus(1'b1, 1'b1, 32'h0003_0004, 8'h99); tick();
    bus(1'b1, 1'b1, 32'h0003_0000, 8'h55); tick();
    bus(1'b1, 1'b0, 32'h0000_0000, 8'h00);
    tx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stop%0d_tv", k), tx_valid, 1'b1);
      chk($sformatf("stop%0d_td", k), tx_data, stop_exp[k]);
      chk($sformatf("stop%0d_done", k), program_done, 1'b0);
      $display("stop pop %h done=%0b", tx_data, program_done);
      tick();
    end
    chk("stop_empty", tx_valid, 1'b0);
    chk("stop_done", program_done, 1'b1);
    bus(1'b1, 1'b1, 32'h0003_0000, 8'h41); tick();
    bus(1'b1, 1'b0, 32'h0000_0000, 8'h00);
    chk("halted_write_ignored", tx_valid, 1'b0);
    chk("halted_done_sticky", program_done, 1'b1);
    $display("halted write 41: tv=%0b done=%0b", tx_valid, program_done);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/io_bus_ctrl.md
# io_bus_ctrl

Memory-mapped I/O controller directly downstream of the `cpu` top's memory bus. It decodes accesses with `mem_a[17:16]==2'b11` and performs four jobs: buffering UART TX bytes, popping UART RX bytes, serving the free-running clock counter, and sequencing the program-stop handshake. It drives `io_buffer_full` back to the cpu. It supplies the read byte and a registered select that the top-level mux uses to choose between RAM and I/O read data.

## Interface
- `TX_DEPTH`, 8: TX FIFO entries; power of two, ≥2.
- `clk_in  input  1`: system clock.
- `rst_in  input  1`: reset, asynchronous, active-low.
- `rdy_in  input  1`: cpu ready. When low, bus accesses are ignored.
- `mem_a  input  32`: cpu address bus. Only `[17:16]` and `[2:0]` are decoded.
- `mem_dout  input  8`: cpu write byte.
- `mem_wr  input  1`: 1 = write, 0 = read.
- `io_din  output  8`: I/O read byte, registered.
- `io_sel_q  output  1`: registered I/O select; top muxes `io_din` into `mem_din` when 1.
- `io_buffer_full  output  1`: TX FIFO full, combinational from count.
- `tx_data  output  8`: FIFO head byte.
- `tx_valid  output  1`: FIFO non-empty.
- `tx_ready  input  1`: UART accepts `tx_data`.
- `rx_data  input  8`: UART received byte.
- `rx_valid  input  1`: RX byte available.
- `rx_pop  output  1`: one-cycle pulse consuming the RX byte.
- `overflow  output  1`: sticky; a TX write was dropped.
- `program_done  output  1`: sticky; stop marker fully transmitted.

## Operation
- Define `io = rdy_in & (mem_a[17:16]==2'b11)`.
- Address offsets are taken from `mem_a[2:0]`.
- **Write, offset 0:**
  - Byte `0x00` is ignored.
  - Otherwise the byte is pushed to the TX FIFO.
- **Write, offset 4:** pushes `0x00` (the stop marker) and moves the state machine RUN→STOPPING.
- **Writes in other states:** in STOPPING and HALTED, all writes are ignored.
- **Writes at other offsets:** ignored.
- **Push when full:**
  - If no pop happens in the same cycle, the byte is dropped and `overflow` is set.
  - If a pop happens in the same cycle, the push is accepted.
  - A dropped stop marker still enters STOPPING, with a pending-marker flag; the marker is pushed on the first cycle the FIFO is not full.
- **Drain:**
  - `tx_valid = count!=0`.
  - A pop occurs on `tx_valid & tx_ready`.
  - Draining is independent of `rdy_in`.
- **State machine:**
  - States: RUN, STOPPING, HALTED.
  - STOPPING→HALTED when the marker has been popped and `count` becomes 0. `program_done`=1 from the next edge onward.
  - HALTED is left only by reset.
- **Read, offset 0:**
  - If `rx_valid`, `rx_pop` pulses in the same cycle and `io_din <= rx_data`.
  - Otherwise `io_din <= 0x00` and there is no pop.
- **Clock counter:**
  - 32-bit `cyc` increments every `clk_in` edge after reset, independent of `rdy_in`; wraps from 0xFFFFFFFF to 0.
  - A read at offset 4 latches `snap <= cyc` and returns `cyc[7:0]`.
  - Reads at offsets 5, 6, 7 return `snap[15:8]`, `snap[23:16]`, `snap[31:24]`. This makes a byte-serial 4-byte read coherent.
- **Read, offsets 1–3:** return 0x00.
- `io_din` holds its value when there is no I/O read.
- **Pointers and count:**
  - Pointers are `log2(TX_DEPTH)` bits and wrap naturally.
  - `count` is `log2(TX_DEPTH)+1` bits.
  - `io_buffer_full = (count==TX_DEPTH)`.

## Timing
- **Reset values:** `io_din`=0, `io_sel_q`=0, `io_buffer_full`=0, `tx_valid`=0, `tx_data`=0, `rx_pop`=0, `overflow`=0, `program_done`=0. State=RUN, pointers=0, count=0, `cyc`=0, `snap`=0.
- **Read latency:** 1 cycle. The address is presented in cycle N; `io_din` and `io_sel_q` are valid in N+1, matching RAM read timing.
- `io_sel_q <= (mem_a[17:16]==2'b11)` when `rdy_in`; it holds when `rdy_in` is low.
- **Write latency:**
  - A push is visible on `tx_valid` the next cycle.
  - A write into an empty FIFO with `tx_ready`=1 yields a pop one cycle after the write.
- **Flags:** `io_buffer_full` reflects the registered count, so it is valid in the same cycle the cpu samples it.
- **Reset mid-operation:**
  - Clears the FIFO, including any unsent bytes.
  - Clears `snap`.
  - Returns the state machine to RUN immediately (asynchronous).

## Test plan
- **Basic TX:** write 0x41 then 0x00 to 0x30000 with `tx_ready`=1 → exactly one byte 0x41 appears on `tx_data` with `tx_valid`; 0x00 is never emitted.
- **Full FIFO and overflow:**
  - Stimulus: `tx_ready`=0, write 9 bytes 0x01..0x09 (TX_DEPTH=8).
  - Expected: `io_buffer_full`=1 after the 8th write; the 9th is dropped; `overflow`=1.
  - Then raise `tx_ready` → drains 0x01..0x08 in order; `io_buffer_full` drops after the first pop.
- **RX read:**
  - With `rx_valid`=1 and `rx_data`=0x5A, read 0x30000 → `rx_pop` pulses the same cycle; `io_din`=0x5A and `io_sel_q`=1 next cycle.
  - With `rx_valid`=0 → `io_din`=0x00 and no `rx_pop`.
- **Coherent counter read:** force `cyc` near 0x000000FE and read 0x30004..0x30007 on consecutive cycles → the assembled word equals the `cyc` value sampled at the 0x30004 read, despite the carry.
- **Program stop:**
  - Stimulus: queue 0x48, 0x49, then write 0x30004.
  - Expected: `tx_data` sequence is 0x48, 0x49, 0x00. `program_done` rises the cycle after the final pop. A later write of 0x41 to 0x30000 is ignored.
- **rdy_in and reset:**
  - With `rdy_in`=0, an I/O write or read causes no push, no `rx_pop`, and no change to `io_sel_q`; `cyc` and the TX drain continue.
  - Asserting `rst_in` low mid-drain clears all outputs immediately.
